// File: rtl/multi_tick_gen_if.sv
// Control/status bundle for multi_tick_gen: run control, divisor write port
// and the per-channel tick/square outputs.
interface multi_tick_gen_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              en;
    logic              sync_clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              cfg_err;

    modport master (
        output en, sync_clr, cfg_we, cfg_ch, cfg_div,
        input  tick, sq, cfg_err
    );

    modport slave (
        input  en, sync_clr, cfg_we, cfg_ch, cfg_div,
        output tick, sq, cfg_err
    );
endinterface

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick / square-wave generator. Each channel emits
// a one-cycle clock enable every div cycles and a square wave of period 2*div.
module multi_tick_gen #(
    parameter int                        NUM_CH    = 3,
    parameter int                        CNT_W     = 32,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_RESET = {32'd50_000, 32'd25_000_000, 32'd50_000_000}
) (
    input  logic               clk,
    input  logic               rst,
    multi_tick_gen_if.slave    bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Out-of-range channel writes are reported but otherwise ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cfg_err <= 1'b0;
        end else begin
            bus.cfg_err <= bus.cfg_we && ({1'b0, bus.cfg_ch} >= (CH_W+1)'(NUM_CH));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_reg;
        logic [CNT_W-1:0] cnt;
        logic             tick_q;
        logic             sq_q;
        logic             wr_hit;
        logic             run;
        logic             term;

        assign wr_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        assign run    = bus.en && (div_reg != '0);
        assign term   = run && (cnt == div_reg - CNT_W'(1));

        // A write in the same cycle as sync_clr still lands; both clear the count
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_reg <= DIV_RESET[i*CNT_W +: CNT_W];
                cnt     <= '0;
                tick_q  <= 1'b0;
                sq_q    <= 1'b0;
            end else begin
                if (wr_hit) begin
                    div_reg <= bus.cfg_div;
                end
                if (bus.sync_clr || wr_hit) begin
                    cnt    <= '0;
                    tick_q <= 1'b0;
                    sq_q   <= 1'b0;
                end else if (term) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    sq_q   <= ~sq_q;
                end else if (run) begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= 1'b0;
                end
            end
        end

        assign bus.tick[i] = tick_q;
        assign bus.sq[i]   = sq_q;
    end
endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen: a count-since-alignment model checked
// every cycle, plus directed scenarios with hand-computed tick timings.
module tb_multi_tick_gen;
    localparam int          NCH   = 3;
    localparam int          CW    = 32;
    localparam logic [95:0] DIV_R = {32'd4, 32'd3, 32'd2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    multi_tick_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) bus();

    multi_tick_gen #(.NUM_CH(NCH), .CNT_W(CW), .DIV_RESET(DIV_R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: enabled edges elapsed since the channel was last aligned.
    // A tick lands whenever that count reaches a multiple of the divisor,
    // and sq is the parity of the number of completed periods.
    longint     div_m [NCH];
    longint     el_m  [NCH];
    logic [2:0] tick_m;
    logic [2:0] sq_m;
    logic       err_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                div_m[i] = longint'(DIV_R[i*CW +: CW]);
                el_m[i]  = 0;
            end
            tick_m = '0;
            sq_m   = '0;
            err_m  = 1'b0;
        end else begin
            err_m = bus.cfg_we && (int'(bus.cfg_ch) >= NCH);
            for (int i = 0; i < NCH; i++) begin
                logic hit;
                hit = bus.cfg_we && (int'(bus.cfg_ch) == i);
                if (hit) div_m[i] = longint'(bus.cfg_div);
                if (bus.sync_clr || hit) begin
                    el_m[i]   = 0;
                    tick_m[i] = 1'b0;
                end else if (bus.en && div_m[i] != 0) begin
                    el_m[i]   = el_m[i] + 1;
                    tick_m[i] = (el_m[i] % div_m[i]) == 0;
                end else begin
                    tick_m[i] = 1'b0;
                end
                sq_m[i] = (div_m[i] == 0) ? 1'b0 : 1'((el_m[i] / div_m[i]) % 2);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_tick", 64'(bus.tick), 64'(tick_m));
        chk("model_sq", 64'(bus.sq), 64'(sq_m));
        chk("model_err", 64'(bus.cfg_err), 64'(err_m));
    end

    task automatic wait_tick(input int ch, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (bus.tick[ch]) begin
                n = k;
                break;
            end
        end
        if (n < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tick%0d timeout after %0d cycles", ch, max);
        end
    endtask

    task automatic cfg_write(input int ch, input int div, input logic clr);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'(ch);
        bus.cfg_div  = 32'(div);
        bus.sync_clr = clr;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        bus.sync_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] t0, t1, t2, s0, s2;
        int n;
        bus.en = 1'b1; bus.sync_clr = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_ch = '0; bus.cfg_div = '0;

        repeat (3) @(negedge clk);
        chk("reset_tick", 64'(bus.tick), 64'd0);
        chk("reset_sq", 64'(bus.sq), 64'd0);
        chk("reset_err", 64'(bus.cfg_err), 64'd0);

        // Reset divisors 2/3/4: record the first 8 cycles after release
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            t0[k] = bus.tick[0]; t1[k] = bus.tick[1]; t2[k] = bus.tick[2];
            s0[k] = bus.sq[0];   s2[k] = bus.sq[2];
        end
        chk("first_tick0", 64'(t0), 64'b1010_1010);
        chk("first_tick1", 64'(t1), 64'b0010_0100);
        chk("first_tick2", 64'(t2), 64'b1000_1000);
        chk("first_sq0", 64'(s0), 64'b0110_0110);
        chk("first_sq2", 64'(s2), 64'b0111_1000);

        // Reprogram ch1 to 5 mid-count
        cfg_write(1, 5, 1'b0);
        wait_tick(1, 20, n);
        chk("div5_first", 64'(n), 64'd5);
        wait_tick(1, 20, n);
        chk("div5_repeat", 64'(n), 64'd5);

        // ch0 div 4, advance to cnt=1, then freeze for 7 cycles
        cfg_write(0, 4, 1'b0);
        @(negedge clk);
        bus.en = 1'b0;
        repeat (7) begin
            @(negedge clk);
            chk("frozen_tick", 64'(bus.tick), 64'd0);
        end
        bus.en = 1'b1;
        wait_tick(0, 20, n);
        chk("resume_tick0", 64'(n), 64'd3);

        // div 1: continuous tick, sq toggles each cycle
        cfg_write(0, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("div1_tick", 64'(bus.tick[0]), 64'd1);
            chk("div1_sq", 64'(bus.sq[0]), 64'((k % 2) == 0));
        end

        // div 0: parked
        cfg_write(0, 0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("div0_tick", 64'(bus.tick[0]), 64'd0);
            chk("div0_sq", 64'(bus.sq[0]), 64'd0);
        end

        // Write to nonexistent channel together with sync_clr
        cfg_write(3, 7, 1'b1);
        chk("err_pulse", 64'(bus.cfg_err), 64'd1);
        @(negedge clk);
        chk("err_clear", 64'(bus.cfg_err), 64'd0);
        wait_tick(1, 20, n);
        chk("clr_tick1", 64'(n), 64'd4);

        // sync_clr + write ch2=6, then reset mid-period
        cfg_write(0, 3, 1'b0);
        cfg_write(2, 6, 1'b1);
        wait_tick(2, 20, n);
        chk("div6_tick2", 64'(n), 64'd6);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_tick", 64'(bus.tick), 64'd0);
        chk("midrst_sq", 64'(bus.sq), 64'd0);
        rst = 1'b0;
        wait_tick(2, 20, n);
        chk("rst_div2", 64'(n), 64'd4);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio 1 Hz divider.
- Produces NUM_CH independent one-cycle enable pulses (tick) and 50%-duty square waves (sq) from the system clock, e.g. 1 Hz seconds, 2 Hz blink and 1 kHz display scan.
- Divisors are programmable at run time; a global enable and a synchronous phase-align clear are provided.
- Downstream logic uses tick as a clock enable on clk, not as a derived clock.

Parameters:
- NUM_CH, 3, number of independent channels (1..16).
- CNT_W, 32, width of each divisor and counter.
- DIV_RESET, {32'd50_000, 32'd25_000_000, 32'd50_000_000}, packed NUM_CH*CNT_W reset divisors; channel i is bits [i*CNT_W +: CNT_W].

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global count enable; low freezes all channels.
- sync_clr  in  1  synchronous clear of all counters and sq; phase-aligns channels.
- cfg_we  in  1  divisor write strobe, one cycle.
- cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH)).
- cfg_div  in  CNT_W  new divisor value.
- tick  out  NUM_CH  one-cycle pulse per channel every div cycles.
- sq  out  NUM_CH  square wave per channel, period 2*div cycles.
- cfg_err  out  1  one-cycle pulse: write to a nonexistent channel.

Behaviour:
- State per channel: div_reg[CNT_W], cnt[CNT_W], sq bit. All outputs are registered.
- Reset (async, takes effect immediately): cnt=0, sq=0, tick=0, cfg_err=0, div_reg=DIV_RESET slice.
- Terminal condition per channel: T = en && div_reg!=0 && cnt==div_reg-1.
- Each rising edge, per channel, in priority order:
  - sync_clr=1: cnt<=0, sq<=0, tick<=0.
  - cfg_we=1 and cfg_ch==i: div_reg<=cfg_div, cnt<=0, sq<=0, tick<=0. The new ratio counts from zero on the next edge.
  - T: cnt<=0, tick<=1, sq<=~sq.
  - en && div_reg!=0: cnt<=cnt+1, tick<=0.
  - Otherwise: hold cnt and sq, tick<=0.
- sync_clr and cfg_we in the same cycle: both apply. div_reg updates and every counter clears.
- Latency: after reset release or a clear, with en held high, the first tick is high in the cycle after the div-th rising edge. Ticks then repeat every div cycles. sq toggles on each tick, so sq goes high with the 1st tick, low with the 2nd, and so on.
- div_reg=1: tick is held high continuously; sq toggles every cycle (period 2).
- div_reg=0: channel is parked. cnt holds 0, tick stays 0, sq holds its value.
- en low: no ticks; cnt and sq hold; counting resumes where it left off. en low does not block cfg writes or sync_clr.
- cfg_we with cfg_ch >= NUM_CH: no state changes; cfg_err=1 for the following cycle, otherwise cfg_err=0.
- Arithmetic: unsigned compare. cnt never exceeds div_reg-1 because every write clears cnt. No overflow path exists; the maximum ratio is 2^CNT_W-1.
- Reset asserted mid-count: everything clears immediately, including div_reg, which returns to DIV_RESET. Runtime writes are not retained.
- Channels are fully independent apart from the shared en and sync_clr.

Test Plan:
- NUM_CH=3, DIV_RESET={4,3,2}, en=1 from reset release → tick[0] high on cycles 2,4,6; tick[1] on 3,6,9; tick[2] on 4,8. sq[0] period 4, sq[2] period 8. All outputs 0 during reset.
- Write cfg_ch=1, cfg_div=5 mid-count → cnt1 and sq[1] cleared; next tick[1] 5 cycles after the write edge, then every 5. Channels 0 and 2 unaffected.
- en low for 7 cycles mid-period (cnt0=1 of div 4) → no ticks, sq frozen. After en rises, tick[0] arrives after exactly 3 more enabled edges.
- cfg_div=1 on ch0 → tick[0] constant 1, sq[0] toggles every cycle. cfg_div=0 → tick[0]=0 indefinitely, sq[0] holds.
- cfg_we with cfg_ch=3 (NUM_CH=3) → cfg_err single pulse next cycle, all divisors unchanged. The same cycle as sync_clr → counters still clear.
- sync_clr and cfg_we (ch2, div 6) together, then rst asserted mid-period → all channels realign; after rst, div2 returns to its reset value 4, not 6.
